// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
// The EX operand forwarding selects, the per-stage stall/flush controls, the PC
// redirect and the mul/div sequencing are all decoded in the same cycle from the
// stage inputs. Only the mul/div sequencing state and the memory-wait counter are
// stored.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs1_i, id_rs2_i            source registers of the instruction in ID
//   ex_rs1_i, ex_rs2_i, ex_rd_i   source and destination registers in EX
//   ex_reg_write_i, ex_mem_read_i EX writes rd / EX is a load
//   ex_branch_taken_i             EX resolved a taken branch or jump
//   ex_mdu_start_i                EX holds a mul/div instruction
//   mem_rd_i, mem_reg_write_i     MEM destination register / write enable
//   mem_req_i, mem_ready_i        data-memory request / ready
//   wb_rd_i, wb_reg_write_i       WB destination register / write enable
//   fwd_a_sel_o, fwd_b_sel_o      forwarding mux select: 00 regfile, 01 WB, 10 MEM
//   stall_*_o                     hold a stage register
//   flush_*_o                     insert a bubble into a stage register
//   pc_sel_o                      1 = take the branch target
//   mdu_done_o                    pulse on the last mul/div cycle
//   mem_fault_o                   pulse on a memory wait timeout
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_LATENCY = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] ex_rs1_i,
    input  logic [4:0] ex_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_reg_write_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_branch_taken_i,
    input  logic       ex_mdu_start_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_reg_write_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_reg_write_i,
    output logic [1:0] fwd_a_sel_o,
    output logic [1:0] fwd_b_sel_o,
    output logic       stall_if_o,
    output logic       stall_id_o,
    output logic       stall_ex_o,
    output logic       stall_mem_o,
    output logic       flush_id_o,
    output logic       flush_ex_o,
    output logic       flush_mem_o,
    output logic       flush_wb_o,
    output logic       pc_sel_o,
    output logic       mdu_done_o,
    output logic       mem_fault_o
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    mdu_cnt_q, mdu_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic       memw;
    logic       load_use;
    logic [1:0] fwd_a, fwd_b;
    logic       st_if, st_id, st_ex, st_mem;
    logic       fl_id, fl_ex, fl_mem, fl_wb;
    logic       pc_sel, mdu_done, mem_fault;

    // The ex_reg_write input is not needed for any decision made here
    logic unused_ok;
    assign unused_ok = ex_reg_write_i;

    // MEM result is newer than WB, so it wins when both match
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             mem_we,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_we,
        input logic [REG_W-1:0] wb_rd
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            return 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(ex_rs1_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);
    assign fwd_b = fwd_sel(ex_rs2_i, mem_reg_write_i, mem_rd_i, wb_reg_write_i, wb_rd_i);

    assign memw     = mem_req_i & ~mem_ready_i;
    assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mdu_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mdu_cnt_q  <= mdu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and hazard control decode; a memory wait overrides everything
    always_comb begin
        state_d    = state_q;
        mdu_cnt_d  = mdu_cnt_q;
        wait_cnt_d = '0;
        st_if      = 1'b0;
        st_id      = 1'b0;
        st_ex      = 1'b0;
        st_mem     = 1'b0;
        fl_id      = 1'b0;
        fl_ex      = 1'b0;
        fl_mem     = 1'b0;
        fl_wb      = 1'b0;
        pc_sel     = 1'b0;
        mdu_done   = 1'b0;
        mem_fault  = 1'b0;

        if (memw) begin
            // Whole pipe freezes, WB gets a bubble; FSM and mdu_cnt hold
            st_if  = 1'b1;
            st_id  = 1'b1;
            st_ex  = 1'b1;
            st_mem = 1'b1;
            fl_wb  = 1'b1;
            if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                mem_fault  = 1'b1;
                wait_cnt_d = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken_i) begin
                        pc_sel = 1'b1;
                        fl_id  = 1'b1;
                        fl_ex  = 1'b1;
                    end else begin
                        if (load_use) begin
                            st_if = 1'b1;
                            st_id = 1'b1;
                            fl_ex = 1'b1;
                        end
                        if (ex_mdu_start_i) begin
                            st_if     = 1'b1;
                            st_id     = 1'b1;
                            st_ex     = 1'b1;
                            fl_mem    = 1'b1;
                            mdu_cnt_d = CNT_W'(MDU_LATENCY - 2);
                            state_d   = ST_MDU_BUSY;
                        end
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_cnt_q != '0) begin
                        st_if     = 1'b1;
                        st_id     = 1'b1;
                        st_ex     = 1'b1;
                        fl_mem    = 1'b1;
                        mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
                    end else begin
                        // Last EX cycle: the instruction leaves EX at this edge
                        mdu_done = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Every output is forced low while reset is held
    assign fwd_a_sel_o = rst ? 2'b00 : fwd_a;
    assign fwd_b_sel_o = rst ? 2'b00 : fwd_b;
    assign stall_if_o  = ~rst & st_if;
    assign stall_id_o  = ~rst & st_id;
    assign stall_ex_o  = ~rst & st_ex;
    assign stall_mem_o = ~rst & st_mem;
    assign flush_id_o  = ~rst & fl_id;
    assign flush_ex_o  = ~rst & fl_ex;
    assign flush_mem_o = ~rst & fl_mem;
    assign flush_wb_o  = ~rst & fl_wb;
    assign pc_sel_o    = ~rst & pc_sel;
    assign mdu_done_o  = ~rst & mdu_done;
    assign mem_fault_o = ~rst & mem_fault;

endmodule
